// File: rtl/seq_match_ctrl_pkg.sv
// Shared types and constants for the serial pattern-match controller.
// Holds the FSM state encoding, parameter defaults and the pattern-length check.
package seq_match_ctrl_pkg;

    localparam int MAX_LEN_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 8;
    localparam int LEN_W           = 4;
    localparam int LEN_MIN         = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A stored length is usable only inside 1..max_len; anything else makes start fail.
    function automatic logic len_valid(input logic [LEN_W-1:0] len, input int max_len);
        return (int'(len) >= LEN_MIN) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_ctrl_core.sv
// Shift history, fill counter and length-masked pattern compare.
// Raises y_raw in the same cycle as the bit that completes a match.
module pattern_match_core
    import seq_match_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               bit_in,
    input  logic               overlap,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               y_raw
);

    // Only MAX_LEN-1 past bits are ever compared; the newest bit comes straight from bit_in.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-2:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic               fill_ok;

    assign window  = {hist_q, bit_in};
    assign fill_p1 = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok = fill_p1 >= {1'b0, len};

    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign y_raw = shift && fill_ok && (((window ^ pattern) & mask) == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (shift) begin
            hist_d = window[MAX_LEN-2:0];
            if (y_raw && !overlap) begin
                fill_d = '0;
            end else if (fill_q < len) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run-control FSM, configuration registers and match counter around pattern_match_core.
// y is a Mealy pulse; err is a registered one-cycle pulse for rejected commands.
module seq_match_ctrl
    import seq_match_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               start,
    input  logic               stop,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               y,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               err
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               run;
    logic               shift;
    logic               start_ok;
    logic               y_raw;
    logic [CNT_W-1:0]   cnt_inc;

    assign run      = (state_q == ST_RUN);
    assign shift    = run && bit_valid && !rst;
    // A same-cycle config write always takes priority over start.
    assign start_ok = !run && start && !cfg_we && len_valid(len_q, MAX_LEN);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .shift   (shift),
        .bit_in  (bit_in),
        .overlap (ovl_q),
        .pattern (pat_q),
        .len     (len_q),
        .y_raw   (y_raw)
    );

    assign y = y_raw;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    ovl_d = cfg_overlap;
                    lim_d = cfg_limit;
                    err_d = start;
                end else if (start) begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                err_d = cfg_we;
                if (y) begin
                    cnt_d = cnt_inc;
                end
                // stop outranks both start and the limit; a match in the same cycle still counts.
                if (stop) begin
                    state_d = ST_DONE;
                end else if (y && (lim_q != '0) && (cnt_inc == lim_q)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            lim_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy      = run;
    assign done      = (state_q == ST_DONE);
    assign match_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed scenarios then random traffic,
// every cycle compared against a bit-list reference model.
module tb_seq_match_ctrl;

    localparam int ML = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, cfg_we, cfg_overlap, start, stop, bit_valid, bit_in;
    logic [ML-1:0] cfg_pattern;
    logic [3:0]    cfg_len;
    logic [CW-1:0] cfg_limit;
    logic          y, busy, done, err;
    logic [CW-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle 1=run 2=done; seg holds bits seen since the last restart point.
    int            m_state = 0;
    logic [ML-1:0] m_pat   = '0;
    int            m_len   = 0;
    logic          m_ovl   = 1'b0;
    int            m_lim   = 0;
    int            m_cnt   = 0;
    logic          m_err   = 1'b0;
    logic          m_y;
    bit            m_seg[$];

    logic          y_last;
    logic [8:0]    y_seen;
    int            bit_idx;
    int            stream[9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};

    seq_match_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .stop        (stop),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_y();
        bit q[$];
        if (rst || m_state != 1 || !bit_valid) return 1'b0;
        q = m_seg;
        q.push_back(bit_in);
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size()-1-k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic e;
        e = 1'b0;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_lim = 0;
            m_seg.delete();
        end else if (m_state == 1) begin
            e = cfg_we;
            if (bit_valid) begin
                m_seg.push_back(bit_in);
                if (m_seg.size() > ML) void'(m_seg.pop_front());
            end
            if (m_y) begin
                m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
                if (!m_ovl) m_seg.delete();
            end
            if (stop) m_state = 2;
            else if (m_y && m_lim != 0 && m_cnt == m_lim) m_state = 2;
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                m_lim = int'(cfg_limit);
                e = start;
            end else if (start) begin
                if (m_len >= 1 && m_len <= ML) begin
                    m_state = 1; m_cnt = 0; m_seg.delete();
                end else begin
                    e = 1'b1;
                end
            end
        end
        m_err = e;
    endtask

    // One clock: check y mid-cycle, advance, check registered outputs, release pulses.
    task automatic tick();
        #1;
        m_y = model_y();
        y_last = y;
        check("y", 32'(y), 32'(m_y));
        @(posedge clk);
        model_edge();
        #1;
        check("busy", 32'(busy), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("match_cnt", 32'(match_cnt), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    endtask

    task automatic do_cfg(input logic [ML-1:0] p, input logic [3:0] l, input logic o,
                          input logic [CW-1:0] lim);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_limit = lim;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_in = b;
        tick();
        if (bit_idx < 9) y_seen[bit_idx] = y_last;
        bit_idx++;
    endtask

    task automatic send_stream(input int n);
        y_seen = '0; bit_idx = 0;
        for (int i = 0; i < n; i++) send_bit(stream[i][0]);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_limit = '0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Start with reset config (len 0) must error and stay idle.
        do_start();
        check("unconfig_start_err", 32'(err), 32'd1);
        tick();
        // Length above MAX_LEN is rejected too.
        do_cfg(8'h0A, 4'd9, 1'b1, 4'd0);
        do_start();
        check("len9_err", 32'(err), 32'd1);

        // Overlapping detection of 1010.
        do_cfg(8'h0A, 4'd4, 1'b1, 4'd0);
        do_start();
        send_stream(9);
        check("ovl_ypos", 32'(y_seen), 32'h150);
        check("ovl_cnt", 32'(match_cnt), 32'd3);
        do_stop();

        // Non-overlapping detection.
        do_cfg(8'h0A, 4'd4, 1'b0, 4'd0);
        do_start();
        send_stream(9);
        check("novl_ypos", 32'(y_seen), 32'h110);
        check("novl_cnt", 32'(match_cnt), 32'd2);
        do_stop();

        // Match limit ends the run after the second match.
        do_cfg(8'h0A, 4'd4, 1'b1, 4'd2);
        do_start();
        send_stream(9);
        check("lim_ypos", 32'(y_seen), 32'h050);
        check("lim_cnt", 32'(match_cnt), 32'd2);
        check("lim_done", 32'(done), 32'd1);

        // Stop after bit 6, reconfigure in DONE, restart clears the count.
        do_cfg(8'h0A, 4'd4, 1'b1, 4'd0);
        check("cfg_done_no_err", 32'(err), 32'd0);
        do_start();
        send_stream(6);
        do_stop();
        check("stop_done", 32'(done), 32'd1);
        check("stop_cnt", 32'(match_cnt), 32'd1);
        do_cfg(8'h0A, 4'd4, 1'b1, 4'd0);
        check("cfg_in_done_err", 32'(err), 32'd0);
        do_start();
        check("restart_cnt", 32'(match_cnt), 32'd0);

        // Config write during RUN errors and leaves the old pattern active.
        do_cfg(8'hFF, 4'd1, 1'b0, 4'd1);
        check("cfg_run_err", 32'(err), 32'd1);
        y_seen = '0; bit_idx = 0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("cfg_run_keep_ypos", 32'(y_seen), 32'h008);

        // stop+start in RUN: stop wins. In DONE: start is taken.
        start = 1'b1; stop = 1'b1; tick();
        check("stopstart_run", 32'(done), 32'd1);
        start = 1'b1; stop = 1'b1; tick();
        check("stopstart_done", 32'(busy), 32'd1);
        do_stop();

        // cfg_we and start together: config written, start ignored, err.
        cfg_we = 1'b1; cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_limit = '0;
        start = 1'b1;
        tick();
        check("cfgstart_err", 32'(err), 32'd1);
        check("cfgstart_not_run", 32'(busy), 32'd0);

        // Reset mid-run aborts and clears configuration.
        do_start();
        send_stream(4);
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        check("rst_idle", 32'(busy | done), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        do_start();
        check("rst_cfg_cleared", 32'(err), 32'd1);

        // Counter saturates at all-ones with a single-bit pattern.
        do_cfg(8'h01, 4'd1, 1'b1, 4'd0);
        do_start();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        check("cnt_sat", 32'(match_cnt), 32'hF);
        do_stop();

        // Full-length pattern.
        do_cfg(8'hB4, 4'd8, 1'b0, 4'd0);
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(cfg_pattern[i]);
        check("len8_cnt", 32'(match_cnt), 32'd1);
        do_stop();

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            cfg_we = ($urandom_range(0, 39) == 0);
            if (cfg_we) begin
                cfg_pattern = ML'($urandom);
                cfg_len     = 4'($urandom_range(0, 10));
                cfg_overlap = 1'($urandom_range(0, 1));
                cfg_limit   = CW'($urandom_range(0, 5));
            end
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            bit_in    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
